shift_ctrl: RTL and testbench
=============================

# shift_ctrl

Sequencer for the serial shift-register datapath. Accepts a WIDTH-bit parallel word through a valid/ready load handshake. Shifts the word out one bit per accepted cycle under a consumer-side ready/valid stall. Reports frame completion with a one-cycle `done` pulse. It is the single point that loads, paces and terminates shift frames, so upstream logic never drives the shift chain directly.

## Interface
- `WIDTH`, 10, number of bits per frame; legal range ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `load_valid`  input  1  parallel word offered.
- `load_ready`  output  1  controller can accept a word.
- `load_data`  input  WIDTH  parallel word to serialise.
- `abort`  input  1  synchronous frame abort.
- `ser_out`  output  1  current serial bit.
- `ser_valid`  output  1  `ser_out` holds a frame bit.
- `ser_ready`  input  1  consumer accepts `ser_out` this cycle.
- `busy`  output  1  frame in progress.
- `done`  output  1  one-cycle pulse after the last bit is accepted.
- `bit_cnt`  output  $clog2(WIDTH+1)  number of bits accepted in the current frame.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `load_ready`=1.
  - A load occurs when `load_valid`&&`load_ready` at a clock edge: `load_data` is captured into the internal shift register, `bit_cnt`←0, and the state goes to SHIFT.
- SHIFT:
  - `ser_valid`=1, `busy`=1, `load_ready`=0.
  - `ser_out` = current head bit: LSB first by default; see Configuration.
  - On each edge with `ser_ready`=1, the register shifts by one and `bit_cnt` increments.
  - On the edge accepting bit WIDTH-1 (`bit_cnt`=WIDTH-1 && `ser_ready`), `bit_cnt`←WIDTH and the state goes to DONE.
  - `ser_ready`=0 holds `ser_out`, `bit_cnt` and state unchanged.
- DONE:
  - `done`=1, `busy`=0, `ser_valid`=0, `load_ready`=0 for exactly one cycle.
  - `bit_cnt` holds WIDTH.
  - Next state is IDLE.
- Abort:
  - `abort`=1 in SHIFT means IDLE next cycle with `bit_cnt`←0 and no `done` pulse.
  - Abort wins over a simultaneous last-bit accept.
  - `abort` is ignored in IDLE and DONE.
- `load_valid` in SHIFT or DONE is ignored; the word is not captured, and upstream must hold it until `load_ready`.
- `ser_out`=0 whenever `ser_valid`=0.
- Arithmetic: `bit_cnt` never exceeds WIDTH and never wraps; it clears to 0 on the next load or abort.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, shift register 0, `bit_cnt`=0.
  - `load_ready`=1, `ser_out`=0, `ser_valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-frame aborts immediately; no `done` pulse.
- Load at edge N: the first bit is valid in cycle N+1.
- With `ser_ready` held at 1, bits appear in cycles N+1…N+WIDTH, `done` in N+WIDTH+1, and `load_ready`=1 in N+WIDTH+2.
- Minimum frame period is WIDTH+2 cycles; back-to-back loads are separated by the DONE and IDLE cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from `ser_ready` or `load_valid` to any output.

## Configuration
- `SHIFT_CTRL_MSB_FIRST_EN`:
  - Defined: `ser_out` presents `load_data[WIDTH-1]` first and the register shifts left.
  - Undefined (default): `load_data[0]` first and the register shifts right.
- State machine, counter and handshake behaviour are identical in both builds.

## Test plan
- Reset check: assert `rst_n`=0 mid-SHIFT → all outputs take reset values within the same cycle; after release, `load_ready`=1 and `done` never pulses.
- Basic frame: WIDTH=10, `load_data`=10'h2A5, `ser_ready`=1 → LSB-first `ser_out` sequence 1,0,1,0,0,1,0,1,0,1 over 10 cycles, `done` pulses at cycle 11, `bit_cnt`=10 during DONE.
- MSB-first build: same stimulus with `SHIFT_CTRL_MSB_FIRST_EN` → sequence 1,0,1,0,1,0,0,1,0,1.
- Stall: `ser_ready` low for 3 cycles after bit 4 → `ser_out` and `bit_cnt`=4 hold; frame finishes 3 cycles later with all 10 bits unchanged.
- Abort vs last bit: `abort`=1 on the same edge that accepts bit 9 → IDLE next cycle, `done` stays 0, `bit_cnt`=0.
- Load blocking: `load_valid`=1 with `load_data`=10'h3FF during SHIFT → no capture and the current frame continues unaltered; the word is captured on the first IDLE cycle.

Source files
------------

// File: rtl/shift_ctrl_if.sv
// Load and serial handshake bundle for shift_ctrl.
// The controller connects through the slave modport, and the producer/consumer side connects through master.
interface shift_ctrl_if #(
  parameter int WIDTH = 10
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output load_valid, load_data, abort, ser_ready,
    input  load_ready, ser_out, ser_valid, busy, done, bit_cnt
  );

  modport slave (
    input  load_valid, load_data, abort, ser_ready,
    output load_ready, ser_out, ser_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/shift_ctrl.sv
// Serial shift-frame sequencer: it loads a parallel word, shifts the word out under ready/valid, and pulses done.
// Bits go out LSB first by default. Define SHIFT_CTRL_MSB_FIRST_EN to send the MSB first and shift left.
module shift_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             head_bit;
  logic [WIDTH-1:0] shreg_next;

`ifdef SHIFT_CTRL_MSB_FIRST_EN
  assign head_bit   = shreg_q[WIDTH-1];
  assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`else
  assign head_bit   = shreg_q[0];
  assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`endif

  // NOTE: every always_comb target gets a default first, so no path leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          shreg_d = bus.load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Abort takes priority, even over the edge that would accept the last bit.
        if (bus.abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.ser_ready) begin
          shreg_d = shreg_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples its _d from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registered state only. No input reaches an output combinationally.
  assign bus.load_ready = (state_q == IDLE);
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.ser_out    = (state_q == SHIFT) & head_bit;
  assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl (WIDTH=10). It covers reset, a basic frame, stall, load blocking, abort, and reset in mid-frame.
module tb_shift_ctrl;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  shift_ctrl_if #(.WIDTH(W)) bus ();

  shift_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SHIFT_CTRL_MSB_FIRST_EN
    return w[W-1-i];
`else
    return w[i];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
    check({tag, ".ser_valid"},  32'(bus.ser_valid),  32'd0);
    check({tag, ".ser_out"},    32'(bus.ser_out),    32'd0);
    check({tag, ".busy"},       32'(bus.busy),       32'd0);
    check({tag, ".done"},       32'(bus.done),       32'd0);
  endtask

  localparam logic [W-1:0] WORD_A = 10'h2A5;
  localparam logic [W-1:0] WORD_B = 10'h3FF;

  initial begin
    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.abort      = 1'b0;
    bus.ser_ready  = 1'b0;

    // Reset state
    #3;
    check_idle("reset");
    check("reset.bit_cnt", 32'(bus.bit_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Basic frame with ser_ready held high
    bus.load_valid = 1'b1;
    bus.load_data  = WORD_A;
    bus.ser_ready  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    check("basic.busy",       32'(bus.busy),       32'd1);
    check("basic.ser_valid",  32'(bus.ser_valid),  32'd1);
    check("basic.load_ready", 32'(bus.load_ready), 32'd0);
    for (int i = 0; i < W; i++) begin
      check($sformatf("basic.ser_out[%0d]", i), 32'(bus.ser_out), 32'(exp_bit(WORD_A, i)));
      check($sformatf("basic.bit_cnt[%0d]", i), 32'(bus.bit_cnt), 32'(i));
      tick();
    end
    check("basic.done",       32'(bus.done),       32'd1);
    check("basic.done_cnt",   32'(bus.bit_cnt),    32'd10);
    check("basic.done_busy",  32'(bus.busy),       32'd0);
    check("basic.done_valid", 32'(bus.ser_valid),  32'd0);
    check("basic.done_out",   32'(bus.ser_out),    32'd0);
    check("basic.done_lrdy",  32'(bus.load_ready), 32'd0);
    tick();
    check_idle("basic.after");
    check("basic.after_cnt", 32'(bus.bit_cnt), 32'd10);

    // Stall after bit 4. A competing 3FF word is offered for the whole frame.
    bus.load_valid = 1'b1;
    bus.load_data  = WORD_A;
    tick();
    bus.load_data = WORD_B;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall.ser_out[%0d]", i), 32'(bus.ser_out), 32'(exp_bit(WORD_A, i)));
      tick();
    end
    bus.ser_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall.hold_out[%0d]", k), 32'(bus.ser_out), 32'(exp_bit(WORD_A, 4)));
      check($sformatf("stall.hold_cnt[%0d]", k), 32'(bus.bit_cnt), 32'd4);
      check($sformatf("stall.hold_busy[%0d]", k), 32'(bus.busy), 32'd1);
      tick();
    end
    bus.ser_ready = 1'b1;
    for (int i = 4; i < W; i++) begin
      check($sformatf("stall.ser_out[%0d]", i), 32'(bus.ser_out), 32'(exp_bit(WORD_A, i)));
      check($sformatf("stall.bit_cnt[%0d]", i), 32'(bus.bit_cnt), 32'(i));
      tick();
    end
    check("stall.done",      32'(bus.done),       32'd1);
    check("stall.done_lrdy", 32'(bus.load_ready), 32'd0);
    tick();
    check("block.idle_lrdy", 32'(bus.load_ready), 32'd1);
    check("block.idle_done", 32'(bus.done),       32'd0);
    tick();
    bus.load_valid = 1'b0;
    check("block.captured_busy", 32'(bus.busy),    32'd1);
    check("block.captured_cnt",  32'(bus.bit_cnt), 32'd0);

    // Accept 9 bits of the 3FF word, then abort on the edge that would accept bit 9.
    for (int i = 0; i < W - 1; i++) begin
      check($sformatf("abort.ser_out[%0d]", i), 32'(bus.ser_out), 32'(exp_bit(WORD_B, i)));
      tick();
    end
    check("abort.pre_cnt", 32'(bus.bit_cnt), 32'd9);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle("abort");
    check("abort.bit_cnt", 32'(bus.bit_cnt), 32'd0);
    tick();
    check("abort.no_done", 32'(bus.done), 32'd0);

    // Abort is ignored in IDLE, and a load still happens.
    bus.abort      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 10'h001;
    tick();
    bus.load_valid = 1'b0;
    check("abort_idle.busy",    32'(bus.busy),    32'd1);
    check("abort_idle.ser_out", 32'(bus.ser_out), 32'(exp_bit(10'h001, 0)));
    tick();
    bus.abort = 1'b0;
    check_idle("abort_early");

    // Reset asserted mid-frame
    bus.load_valid = 1'b1;
    bus.load_data  = WORD_A;
    tick();
    bus.load_valid = 1'b0;
    tick();
    tick();
    check("midrst.pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst.bit_cnt", 32'(bus.bit_cnt), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst.no_done[%0d]", k), 32'(bus.done), 32'd0);
      check($sformatf("midrst.lrdy[%0d]", k), 32'(bus.load_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
